sha1_msg_sequencer: RTL

- Streams an arbitrary-length byte message, 32-bit word at a time, into the single-block SHA-1 compression core.
- Assembles 512-bit blocks and applies FIPS 180-4 padding: 0x80 marker, zero fill and 64-bit big-endian bit length.
- Issues one core_start per block, with chaining across blocks, and presents the final 160-bit digest.
- Sits between the host/bus word stream and the sha1 core; it is the only master of the core.

---
 rtl/sha1_pkg.sv | 31 +++
 rtl/sha1_pad_block.sv | 40 ++++
 rtl/sha1_msg_sequencer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/sha1_pkg.sv
// Shared types and constants for the SHA-1 message sequencer and its padding logic.
package sha1_pkg;

  localparam int BLOCK_WORDS = 16;
  localparam int WORD_W      = 32;
  localparam int BLOCK_W     = BLOCK_WORDS * WORD_W;
  localparam int DIGEST_W    = 160;

  localparam logic [WORD_W-1:0]   PAD_MARKER = 32'h80000000;
  localparam logic [DIGEST_W-1:0] SHA1_IV    = {32'h67452301, 32'hEFCDAB89, 32'h98BADCFE,
                                                32'h10325476, 32'hC3D2E1F0};

  typedef enum logic [2:0] {IDLE, FILL, RUN, PAD, LEN_BLK, ERR} state_e;

  typedef enum logic [1:0] {PM_FINAL, PM_OVERFLOW, PM_LEN_ONLY} pad_mode_e;

  // Keep the first n message bytes of the last word and place 0x80 right after them;
  // n == 0 stands for a full word, so the marker occupies a fresh word.
  function automatic logic [WORD_W-1:0] mark_word(input logic [WORD_W-1:0] w,
                                                  input logic [1:0] n);
    logic [WORD_W-1:0] r;
    case (n)
      2'd1:    r = {w[31:24], 8'h80, 16'h0000};
      2'd2:    r = {w[31:16], 8'h80, 8'h00};
      2'd3:    r = {w[31:8], 8'h80};
      default: r = PAD_MARKER;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sha1_pad_block.sv
// Combinational construction of a padded SHA-1 block: final block with length,
// overflow block (marker only), or a length-only trailer block.
module sha1_pad_block
  import sha1_pkg::*;
(
  input  logic [BLOCK_W-1:0] blk_in,
  input  logic [4:0]         p,
  input  logic [1:0]         n,
  input  logic [63:0]        length,
  input  pad_mode_e          mode,
  output logic [BLOCK_W-1:0] blk_out
);

  logic [WORD_W-1:0] word_in;
  logic [WORD_W-1:0] word_out;

  always_comb begin
    blk_out  = '0;
    word_in  = '0;
    word_out = '0;
    for (int i = 0; i < BLOCK_WORDS; i++) begin
      word_in  = blk_in[BLOCK_W - WORD_W*(i+1) +: WORD_W];
      word_out = '0;
      if (mode == PM_LEN_ONLY) begin
        // A message ending exactly on a block boundary still owes its marker.
        if (i == 0 && p == 5'd16) word_out = PAD_MARKER;
      end else if (5'(i) < p) begin
        word_out = word_in;
      end else if (5'(i) == p) begin
        word_out = mark_word(word_in, n);
      end
      if (mode != PM_OVERFLOW) begin
        if (i == 14) word_out = length[63:32];
        if (i == 15) word_out = length[31:0];
      end
      blk_out[BLOCK_W - WORD_W*(i+1) +: WORD_W] = word_out;
    end
  end

endmodule

// File: rtl/sha1_msg_sequencer.sv
// Streams a byte message into a single-block SHA-1 core: block assembly, padding,
// chaining, timeout supervision and final digest capture.
module sha1_msg_sequencer
  import sha1_pkg::*;
#(
  parameter int CORE_TIMEOUT = 1023,
  parameter int LEN_W        = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                abort,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WORD_W-1:0]   in_data,
  input  logic                in_last,
  input  logic [1:0]          in_bytes,
  output logic                core_start,
  output logic                core_first,
  output logic [BLOCK_W-1:0]  core_block,
  input  logic                core_done,
  input  logic [DIGEST_W-1:0] core_digest,
  output logic [DIGEST_W-1:0] digest,
  output logic                digest_valid,
  output logic                busy,
  output logic                error
);

  localparam int TW = $clog2(CORE_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(CORE_TIMEOUT - 1);

  state_e           state;
  logic [3:0]       wcnt;
  logic [LEN_W-1:0] len_q;
  logic [4:0]       p_q;
  logic [1:0]       n_q;
  logic             first_blk;
  logic             final_blk;
  logic             need_len;
  logic [TW-1:0]    tcnt;

  logic             accept;
  logic [5:0]       add_bits;
  logic [LEN_W-1:0] len_next;
  logic [8:0]       slot_lsb;
  logic [63:0]      len64;
  pad_mode_e        pad_mode;
  logic [BLOCK_W-1:0] pad_out;

  assign in_ready = (state == IDLE) || (state == FILL);
  assign busy     = (state != IDLE);
  assign accept   = in_valid && in_ready;
  assign add_bits = (in_last && in_bytes != 2'd0) ? {1'b0, in_bytes, 3'b000} : 6'd32;
  assign len_next = ((state == IDLE) ? '0 : len_q) + LEN_W'(add_bits);
  assign slot_lsb = {~wcnt, 5'b00000};
  assign len64    = 64'(len_q);
  assign pad_mode = (state == LEN_BLK) ? PM_LEN_ONLY :
                    (p_q <= 5'd13)     ? PM_FINAL : PM_OVERFLOW;

  sha1_pad_block u_pad (
    .blk_in  (core_block),
    .p       (p_q),
    .n       (n_q),
    .length  (len64),
    .mode    (pad_mode),
    .blk_out (pad_out)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      wcnt         <= '0;
      len_q        <= '0;
      p_q          <= '0;
      n_q          <= '0;
      first_blk    <= 1'b0;
      final_blk    <= 1'b0;
      need_len     <= 1'b0;
      tcnt         <= '0;
      core_start   <= 1'b0;
      core_first   <= 1'b0;
      core_block   <= '0;
      digest       <= '0;
      digest_valid <= 1'b0;
      error        <= 1'b0;
    end else if (abort) begin
      state        <= IDLE;
      wcnt         <= '0;
      len_q        <= '0;
      p_q          <= '0;
      n_q          <= '0;
      first_blk    <= 1'b0;
      final_blk    <= 1'b0;
      need_len     <= 1'b0;
      tcnt         <= '0;
      core_start   <= 1'b0;
      core_first   <= 1'b0;
      core_block   <= '0;
      digest       <= '0;
      digest_valid <= 1'b0;
      error        <= 1'b0;
    end else begin
      core_start   <= 1'b0;
      digest_valid <= 1'b0;
      case (state)
        IDLE, FILL: begin
          if (accept) begin
            core_block[slot_lsb +: WORD_W] <= in_data;
            wcnt  <= wcnt + 4'd1;
            len_q <= len_next;
            if (state == IDLE) first_blk <= 1'b1;
            if (in_last) begin
              // Full last word pushes the marker into the following slot.
              p_q   <= {1'b0, wcnt} + {4'b0000, (in_bytes == 2'd0)};
              n_q   <= in_bytes;
              wcnt  <= '0;
              state <= PAD;
            end else if (wcnt == 4'd15) begin
              core_start <= 1'b1;
              core_first <= (state == IDLE) ? 1'b1 : first_blk;
              final_blk  <= 1'b0;
              need_len   <= 1'b0;
              tcnt       <= '0;
              state      <= RUN;
            end else begin
              state <= FILL;
            end
          end
        end
        PAD: begin
          core_block <= pad_out;
          core_start <= 1'b1;
          core_first <= first_blk;
          tcnt       <= '0;
          final_blk  <= (p_q <= 5'd13);
          need_len   <= (p_q > 5'd13);
          state      <= RUN;
        end
        RUN: begin
          if (core_done) begin
            if (final_blk) begin
              digest       <= core_digest;
              digest_valid <= 1'b1;
              final_blk    <= 1'b0;
              state        <= IDLE;
            end else begin
              first_blk <= 1'b0;
              state     <= need_len ? LEN_BLK : FILL;
            end
          end else if (tcnt == TO_LAST) begin
            error <= 1'b1;
            state <= ERR;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        LEN_BLK: begin
          core_block <= pad_out;
          core_start <= 1'b1;
          core_first <= first_blk;
          tcnt       <= '0;
          final_blk  <= 1'b1;
          need_len   <= 1'b0;
          state      <= RUN;
        end
        ERR: begin
          state <= ERR;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
